// File: rtl/hazard_ctrl.sv
// Read-port hazard scheduler beside ID: shadow EX/MEM/WB writer slots drive stall/bubble,
// EX operand-forward selects and a saturating stall counter. Forwarding enabled by HAZARD_FORWARD_EN.
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wd,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              mem_hold,
  output logic              stall,
  output logic              bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              v;
    logic              wr;
    logic [REG_AW-1:0] wd;
    logic              ld;
  } slot_t;

  slot_t ex_slot, mem_slot, wb_slot;

  logic       ex_a, ex_b, mem_a, mem_b;
  logic       hazard;
  logic [1:0] fa_raw, fb_raw;
  logic       cnt_inc;

  // $0 is hardwired zero, so a writer to it can never be a real producer.
  function automatic logic slot_match(input slot_t s, input logic [REG_AW-1:0] r,
                                      input logic use_r);
    return s.v && s.wr && (s.wd == r) && (r != '0) && use_r;
  endfunction

  assign ex_a  = slot_match(ex_slot,  id_rs, id_use_rs);
  assign ex_b  = slot_match(ex_slot,  id_rt, id_use_rt);
  assign mem_a = slot_match(mem_slot, id_rs, id_use_rs);
  assign mem_b = slot_match(mem_slot, id_rt, id_use_rt);

`ifdef HAZARD_FORWARD_EN
  // Only a load in EX cannot be bypassed; EX result wins over the older MEM result.
  assign hazard = (ex_a || ex_b) && ex_slot.ld;
  assign fa_raw = (ex_a && !ex_slot.ld) ? 2'b01 : (mem_a ? 2'b10 : 2'b00);
  assign fb_raw = (ex_b && !ex_slot.ld) ? 2'b01 : (mem_b ? 2'b10 : 2'b00);

  logic unused_state;
  assign unused_state = ^{wb_slot, mem_slot.ld};
`else
  // No bypass paths: wait until the producer has left MEM.
  assign hazard = ex_a || ex_b || mem_a || mem_b;
  assign fa_raw = 2'b00;
  assign fb_raw = 2'b00;

  logic unused_state;
  assign unused_state = ^{wb_slot, mem_slot.ld, ex_slot.ld};
`endif

  assign stall   = (hazard && id_valid && !flush) || mem_hold;
  assign bubble  = ((hazard && id_valid) || flush) && !mem_hold;
  assign fwd_a   = bubble ? 2'b00 : fa_raw;
  assign fwd_b   = bubble ? 2'b00 : fb_raw;
  assign cnt_inc = hazard && id_valid && !flush && !mem_hold;

  // WB never affects outputs: the register file writes before it reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot   <= '0;
      mem_slot  <= '0;
      wb_slot   <= '0;
      stall_cnt <= '0;
    end else if (!mem_hold) begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      if (id_valid && !bubble) begin
        ex_slot <= '{v: 1'b1, wr: id_wr_en, wd: id_wd, ld: id_is_load};
      end else begin
        ex_slot <= '0;
      end
      if (cnt_inc && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector bench for hazard_ctrl; a second instance with a 2-bit counter covers saturation.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_wd = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_wr_en = 1'b0, id_is_load = 1'b0;
  logic       flush = 1'b0, mem_hold = 1'b0;

  logic        stall, bubble, s_stall, s_bubble;
  logic [1:0]  fwd_a, fwd_b, s_fwd_a, s_fwd_b;
  logic [31:0] stall_cnt;
  logic [1:0]  s_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_wd(id_wd),
    .id_is_load(id_is_load), .flush(flush), .mem_hold(mem_hold),
    .stall(stall), .bubble(bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.REG_AW(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_wd(id_wd),
    .id_is_load(id_is_load), .flush(flush), .mem_hold(mem_hold),
    .stall(s_stall), .bubble(s_bubble), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_cnt)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt, we;
    logic [4:0] wd;
    logic       ld, fl, mh;
    logic       st, bb;
    logic [1:0] fa, fb;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input int rs, input int rt, input logic urs,
                              input logic urt, input logic we, input int wd, input logic ld,
                              input logic fl, input logic mh, input logic st, input logic bb,
                              input int fa, input int fb, input int cnt);
    vec_t t;
    t.v = v; t.rs = 5'(rs); t.rt = 5'(rt); t.urs = urs; t.urt = urt; t.we = we;
    t.wd = 5'(wd); t.ld = ld; t.fl = fl; t.mh = mh; t.st = st; t.bb = bb;
    t.fa = 2'(fa); t.fb = 2'(fb); t.cnt = 32'(cnt);
    return t;
  endfunction

  task automatic drive(input vec_t t);
    id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_use_rs = t.urs; id_use_rt = t.urt;
    id_wr_en = t.we; id_wd = t.wd; id_is_load = t.ld; flush = t.fl; mem_hold = t.mh;
  endtask

  task automatic check(input string name, input logic st, input logic bb, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [31:0] cnt);
    logic [1:0] scnt;
    scnt = (cnt > 32'd3) ? 2'd3 : cnt[1:0];
    n_vec++;
    if (stall !== st) begin
      n_err++; $display("FAIL %s stall: got %b want %b", name, stall, st);
    end
    if (bubble !== bb) begin
      n_err++; $display("FAIL %s bubble: got %b want %b", name, bubble, bb);
    end
    if (fwd_a !== fa) begin
      n_err++; $display("FAIL %s fwd_a: got %b want %b", name, fwd_a, fa);
    end
    if (fwd_b !== fb) begin
      n_err++; $display("FAIL %s fwd_b: got %b want %b", name, fwd_b, fb);
    end
    if (stall_cnt !== cnt) begin
      n_err++; $display("FAIL %s stall_cnt: got %0d want %0d", name, stall_cnt, cnt);
    end
    if (s_cnt !== scnt) begin
      n_err++; $display("FAIL %s sat_cnt: got %0d want %0d", name, s_cnt, scnt);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic apply(input vec_t t, input string name);
    drive(t);
    @(negedge clk);
    check(name, t.st, t.bb, t.fa, t.fb, t.cnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
`ifdef HAZARD_FORWARD_EN
    tbl.push_back(mk(0, 0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1, 1, 2,1,1,1, 3,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1, 3, 7,1,1,1, 8,0,0,0, 0,0,1,0,0));
    tbl.push_back(mk(1, 9,10,1,1,0, 0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1, 8, 8,1,0,0, 0,0,0,0, 0,0,2,0,0));
    tbl.push_back(mk(1, 8, 0,1,0,0, 0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1, 1, 0,1,0,1, 4,1,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1, 2, 4,1,1,1,11,0,0,0, 1,1,0,0,0));
    tbl.push_back(mk(1, 2, 4,1,1,1,11,0,0,0, 0,0,0,2,1));
    tbl.push_back(mk(1, 1, 0,1,0,1, 0,0,0,0, 0,0,0,0,1));
    tbl.push_back(mk(1, 0, 0,1,1,0, 0,0,0,0, 0,0,0,0,1));
    tbl.push_back(mk(1, 1, 0,1,0,1, 5,1,0,0, 0,0,0,0,1));
    tbl.push_back(mk(1, 5, 0,1,0,1,12,0,1,0, 0,1,0,0,1));
    tbl.push_back(mk(1,12, 5,1,1,0, 0,0,0,0, 0,0,0,2,1));
    tbl.push_back(mk(1, 1, 0,1,0,1, 6,1,0,0, 0,0,0,0,1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1,6,0,1,0,1,13,0,0,1, 1,0,0,0,1));
    tbl.push_back(mk(1, 6, 0,1,0,1,13,0,0,0, 1,1,0,0,1));
    tbl.push_back(mk(1, 6, 0,1,0,1,13,0,0,0, 0,0,2,0,2));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0,0,0,0, 0,0,0,0,2));
    cnt = 2;
`else
    tbl.push_back(mk(0, 0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1, 1, 0,1,0,1, 6,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1, 6, 6,1,1,1, 7,0,0,0, 1,1,0,0,0));
    tbl.push_back(mk(1, 6, 6,1,1,1, 7,0,0,0, 1,1,0,0,1));
    tbl.push_back(mk(1, 6, 6,1,1,1, 7,0,0,0, 0,0,0,0,2));
    tbl.push_back(mk(1, 1, 0,1,0,0, 0,0,0,0, 0,0,0,0,2));
    tbl.push_back(mk(1, 7, 0,1,0,0, 0,0,0,0, 1,1,0,0,2));
    tbl.push_back(mk(1, 7, 0,1,0,0, 0,0,0,0, 0,0,0,0,3));
    tbl.push_back(mk(1, 1, 0,1,0,1, 0,0,0,0, 0,0,0,0,3));
    tbl.push_back(mk(1, 0, 0,1,1,0, 0,0,0,0, 0,0,0,0,3));
    tbl.push_back(mk(1, 1, 0,1,0,1, 5,1,0,0, 0,0,0,0,3));
    tbl.push_back(mk(1, 5, 0,1,0,1,12,0,1,0, 0,1,0,0,3));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1,12,5,1,1,0,0,0,0,1, 1,0,0,0,3));
    tbl.push_back(mk(1,12, 5,1,1,0, 0,0,0,0, 1,1,0,0,3));
    tbl.push_back(mk(1,12, 5,1,1,0, 0,0,0,0, 0,0,0,0,4));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0,0,0,0, 0,0,0,0,4));
    cnt = 4;
`endif

    // Reset block: hold reset across a few edges, check the cleared outputs.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Repeated load-use on $20: pushes the 2-bit counter into saturation.
    for (int k = 0; k < 3; k++) begin
      apply(mk(1, 1,0,1,0,1,20,1,0,0, 0,0,0,0,cnt), $sformatf("lu%0d_lw", k));
      apply(mk(1,20,0,1,0,0, 0,0,0,0, 1,1,0,0,cnt), $sformatf("lu%0d_r1", k));
`ifdef HAZARD_FORWARD_EN
      cnt = cnt + 1;
      apply(mk(1,20,0,1,0,0, 0,0,0,0, 0,0,2,0,cnt), $sformatf("lu%0d_r2", k));
`else
      cnt = cnt + 1;
      apply(mk(1,20,0,1,0,0, 0,0,0,0, 1,1,0,0,cnt), $sformatf("lu%0d_r2", k));
      cnt = cnt + 1;
`endif
      apply(mk(1,20,0,1,0,0, 0,0,0,0, 0,0,0,0,cnt), $sformatf("lu%0d_r3", k));
    end

    // Asynchronous reset in the middle of a pending hazard.
    apply(mk(1, 1,0,1,0,1,21,1,0,0, 0,0,0,0,cnt), "ar_lw");
    drive(mk(1,21,0,1,0,0, 0,0,0,0, 1,1,0,0,cnt));
    @(negedge clk);
    check("ar_pending", 1'b1, 1'b1, 2'b00, 2'b00, 32'(cnt));
    #2 rst_n = 1'b0;
    #1 check("ar_async", 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply(mk(1,21,0,1,0,0, 0,0,0,0, 0,0,0,0,0), "ar_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Read-port hazard scheduler for the 5-stage MIPS pipeline; sits beside the ID stage, after the per-instruction read-port decode.
- Keeps a shadow pipeline (EX/MEM/WB) of in-flight register writers and compares it against the source registers the ID instruction actually reads.
- Issues stall/bubble to the pipeline registers, operand-forwarding selects to the EX muxes, and keeps a stall-cycle counter.

Parameters:
REG_AW, 5, register-index width
CNT_W, 32, stall-counter width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_AW  ID source A index
id_rt  in  REG_AW  ID source B index
id_use_rs  in  1  ID instruction reads rs (from read-port decode)
id_use_rt  in  1  ID instruction reads rt
id_wr_en  in  1  ID instruction writes the register file
id_wd  in  REG_AW  ID destination index
id_is_load  in  1  ID instruction is a load (data available only after MEM)
flush  in  1  branch/jump taken in EX; ID instruction is killed
mem_hold  in  1  memory not ready; entire pipeline frozen
stall  out  1  hold PC, IF/ID
bubble  out  1  insert NOP into ID/EX
fwd_a  out  2  EX operand A source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
fwd_b  out  2  same for operand B
stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- State: three slots EX, MEM, WB, each holding {v, wr, wd, ld}. Reset clears all fields, so all slots are invalid. stall_cnt resets to 0.
- stall, bubble, fwd_a and fwd_b are combinational from slots and ID inputs. After reset they are all 0.
- A slot matches source s when: v && wr && wd==s && s!=0 && the matching use_* bit is set. Register $0 never creates a hazard.
- Forwarding mode (see Optional Feature):
  - hazard = EX slot matches either source && EX.ld (load-use).
  - fwd_x = 01 if the EX slot matches and it is not a load.
  - Otherwise fwd_x = 10 if the MEM slot matches.
  - Otherwise fwd_x = 00. The EX slot has priority over the MEM slot.
- The WB slot never causes a hazard or a forward; the register file writes before it reads within a cycle.
- Outputs:
  - stall = (hazard && id_valid && !flush) || mem_hold.
  - bubble = ((hazard && id_valid) || flush) && !mem_hold.
  - fwd_x is forced to 00 whenever bubble=1.
- Slot update on rising clk when !mem_hold:
  - WB<=MEM, MEM<=EX.
  - EX<={1,id_wr_en,id_wd,id_is_load} if id_valid && !bubble, else EX is invalid.
- When mem_hold=1, all slots and stall_cnt hold.
- stall_cnt increments by 1 on each edge where hazard && id_valid && !flush && !mem_hold. It saturates at all-ones and never wraps.
- flush and hazard in the same cycle: flush wins. The ID instruction is killed, there is no stall, and the EX slot becomes invalid.
- Load-use resolves in exactly one stall cycle: the load moves to MEM, and the next cycle forwards 10.
- Reset asserted mid-operation clears all slots immediately (asynchronous), with no pending stall.

Optional Feature:
- Macro HAZARD_FORWARD_EN.
- Defined: forwarding behaviour as above.
- Undefined:
  - fwd_a and fwd_b are tied to 00.
  - hazard = EX or MEM slot matches (any type).
  - A dependent instruction stalls until its producer reaches WB: 2 stall cycles for an adjacent producer, 1 cycle for a producer two instructions ahead.

Test Plan:
1. add $3 writer then ID add reading rs=$3, use_rs=1 (forwarding) -> stall=0, fwd_a=01; next cycle, with an independent instruction in ID and the writer in MEM, fwd_a=00.
2. lw $4 then ID instruction reading rt=$4 -> stall=1, bubble=1 for one cycle, stall_cnt 0->1; next cycle stall=0, fwd_b=10.
3. Writer to $0 followed by a reader of $0 -> stall=0, fwd_a=fwd_b=00.
4. lw $5 in EX, ID reads $5, flush=1 in the same cycle -> stall=0, bubble=1; the next EX slot is invalid and stall_cnt is unchanged.
5. mem_hold=1 for 3 cycles during a load-use hazard -> stall=1, bubble=0, slots frozen, stall_cnt unchanged; the hazard resolves in one cycle after release.
6. Without HAZARD_FORWARD_EN: adjacent add $6 producer and consumer -> stall=1 for 2 cycles, fwd=00, stall_cnt +2; preload stall_cnt to all-ones -> it holds at all-ones.
